// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - 24-voice sine mixer sharing one table, saturating signed 16-bit output
module voice_mixer #(
  parameter int NUM_VOICES = 24,
  parameter int OUT_SHIFT  = 3,
  parameter int ACC_W      = 21
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     sample_tick_in,
  input  logic [NUM_VOICES-1:0]    gate_in,
  input  logic [31:0]              phase_in [NUM_VOICES-1:0],
  output logic signed [15:0]       sample_out,
  output logic                     sample_valid_out,
  output logic [4:0]               active_count_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  localparam logic [4:0]              LAST_VOICE = 5'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-32768);

  state_t                    state_q;
  state_t                    state_d;
  logic                      load;
  logic                      issue;

  logic [7:0]                snap_index [NUM_VOICES-1:0];
  logic [NUM_VOICES-1:0]     snap_gate;
  logic [4:0]                voice_q;

  logic [7:0]                rom_addr_q;
  logic signed [15:0]        rom_data_q;
  logic                      gate_d1;
  logic                      gate_d2;
  logic                      last_d1;
  logic                      last_d2;

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_shifted;
  logic signed [15:0]        mix_sat;
  logic [4:0]                gate_count;
  logic                      phase_low_unused;

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
  function automatic logic [14:0] quarter_sine(input logic [6:0] k);
    logic [14:0] q;
    case (k)
      7'd0:  q = 15'd0;
      7'd1:  q = 15'd804;
      7'd2:  q = 15'd1608;
      7'd3:  q = 15'd2410;
      7'd4:  q = 15'd3212;
      7'd5:  q = 15'd4011;
      7'd6:  q = 15'd4808;
      7'd7:  q = 15'd5602;
      7'd8:  q = 15'd6393;
      7'd9:  q = 15'd7179;
      7'd10: q = 15'd7962;
      7'd11: q = 15'd8739;
      7'd12: q = 15'd9512;
      7'd13: q = 15'd10278;
      7'd14: q = 15'd11039;
      7'd15: q = 15'd11793;
      7'd16: q = 15'd12539;
      7'd17: q = 15'd13279;
      7'd18: q = 15'd14010;
      7'd19: q = 15'd14732;
      7'd20: q = 15'd15446;
      7'd21: q = 15'd16151;
      7'd22: q = 15'd16846;
      7'd23: q = 15'd17530;
      7'd24: q = 15'd18204;
      7'd25: q = 15'd18868;
      7'd26: q = 15'd19519;
      7'd27: q = 15'd20159;
      7'd28: q = 15'd20787;
      7'd29: q = 15'd21403;
      7'd30: q = 15'd22005;
      7'd31: q = 15'd22594;
      7'd32: q = 15'd23170;
      7'd33: q = 15'd23731;
      7'd34: q = 15'd24279;
      7'd35: q = 15'd24811;
      7'd36: q = 15'd25329;
      7'd37: q = 15'd25832;
      7'd38: q = 15'd26319;
      7'd39: q = 15'd26790;
      7'd40: q = 15'd27245;
      7'd41: q = 15'd27683;
      7'd42: q = 15'd28105;
      7'd43: q = 15'd28510;
      7'd44: q = 15'd28898;
      7'd45: q = 15'd29268;
      7'd46: q = 15'd29621;
      7'd47: q = 15'd29956;
      7'd48: q = 15'd30273;
      7'd49: q = 15'd30571;
      7'd50: q = 15'd30852;
      7'd51: q = 15'd31113;
      7'd52: q = 15'd31356;
      7'd53: q = 15'd31580;
      7'd54: q = 15'd31785;
      7'd55: q = 15'd31971;
      7'd56: q = 15'd32137;
      7'd57: q = 15'd32285;
      7'd58: q = 15'd32412;
      7'd59: q = 15'd32521;
      7'd60: q = 15'd32609;
      7'd61: q = 15'd32678;
      7'd62: q = 15'd32728;
      7'd63: q = 15'd32757;
      7'd64: q = 15'd32767;
      default: q = 15'd0;
    endcase
    return q;
  endfunction

  // Full 256-entry table folded onto the quarter wave: odd quadrants mirror, upper half negates
  function automatic logic signed [15:0] sine_lookup(input logic [7:0] idx);
    logic [6:0]         k;
    logic signed [15:0] mag;
    k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = signed'({1'b0, quarter_sine(k)});
    return idx[7] ? -mag : mag;
  endfunction

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick_in) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (voice_q == LAST_VOICE) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_d2) state_d = OUTPUT;
      end
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot of table indices and gates taken on an accepted tick
  always_ff @(posedge clk_in) begin
    if (load) begin
      snap_gate <= gate_in;
      for (int i = 0; i < NUM_VOICES; i++) snap_index[i] <= phase_in[i][31:24];
    end
  end

  // Voice counter walks 0..23 while issuing and rests at 0 otherwise
  always_ff @(posedge clk_in) begin
    if (rst_in)                            voice_q <= '0;
    else if (issue && voice_q != LAST_VOICE) voice_q <= voice_q + 5'd1;
    else                                   voice_q <= '0;
  end

  // Table read port: registered address then registered data
  always_ff @(posedge clk_in) begin
    rom_addr_q <= snap_index[voice_q];
    rom_data_q <= sine_lookup(rom_addr_q);
  end

  // Gate-qualify and last-voice markers travel alongside the table read
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_d1 <= 1'b0;
      gate_d2 <= 1'b0;
      last_d1 <= 1'b0;
      last_d2 <= 1'b0;
    end else begin
      gate_d1 <= issue && snap_gate[voice_q];
      gate_d2 <= gate_d1;
      last_d1 <= issue && (voice_q == LAST_VOICE);
      last_d2 <= last_d1;
    end
  end

  // Accumulate gated voice samples, cleared at the start of each mix
  always_ff @(posedge clk_in) begin
    if (rst_in)       acc_q <= '0;
    else if (load)    acc_q <= '0;
    else if (gate_d2) acc_q <= acc_q + ACC_W'(rom_data_q);
  end

  assign acc_shifted = acc_q >>> OUT_SHIFT;

  // Clamp the scaled sum into the signed 16-bit range
  always_comb begin
    mix_sat = acc_shifted[15:0];
    if (acc_shifted > SAT_MAX)      mix_sat = 16'sh7FFF;
    else if (acc_shifted < SAT_MIN) mix_sat = 16'sh8000;
  end

  // Number of voices gated in the snapshot
  always_comb begin
    gate_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) gate_count = gate_count + {4'd0, snap_gate[i]};
  end

  // Low phase bits only matter upstream; fold them into a sink
  always_comb begin
    phase_low_unused = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) phase_low_unused = phase_low_unused ^ (^phase_in[i][23:0]);
  end

  // Output registers: result and count load in the OUTPUT cycle and hold until the next one
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      active_count_out <= '0;
      overrun_out      <= 1'b0;
    end else begin
      sample_valid_out <= (state_q == OUTPUT);
      if (state_q == OUTPUT) begin
        sample_out       <= mix_sat;
        active_count_out <= gate_count;
      end
      if (sample_tick_in && state_q != IDLE) overrun_out <= 1'b1;
    end
  end

  assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer
module tb_voice_mixer;

  localparam int  NV = 24;
  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               rst;
  logic               tick;
  logic [NV-1:0]      gate;
  logic [31:0]        phase [NV-1:0];
  logic signed [15:0] sample;
  logic               valid;
  logic [4:0]         acount;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] gate;
    logic [7:0]  idx_even;
    logic [7:0]  idx_odd;
    int          exp_sample;
    int          exp_count;
  } vec_t;

  vec_t vecs [12];

  voice_mixer dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_tick_in   (tick),
    .gate_in          (gate),
    .phase_in         (phase),
    .sample_out       (sample),
    .sample_valid_out (valid),
    .active_count_out (acount),
    .busy_out         (busy),
    .overrun_out      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sine_ref(input int idx);
    return int'(32767.0 * $sin(2.0 * PI * real'(idx) / 256.0));
  endfunction

  // Reference: sum of gated sines, floor-divide by 8, clamp to 16-bit signed
  task automatic model(output int exp_s, output int exp_c);
    int sum;
    sum   = 0;
    exp_c = 0;
    for (int v = 0; v < NV; v++) begin
      if (gate[v]) begin
        sum += sine_ref(int'(phase[v][31:24]));
        exp_c++;
      end
    end
    exp_s = int'($floor(real'(sum) / 8.0));
    if (exp_s > 32767)  exp_s = 32767;
    if (exp_s < -32768) exp_s = -32768;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for valid after a tick; lat returns cycles since the tick edge, 99 on timeout
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!valid && lat < 60) begin
      step();
      lat++;
    end
    if (!valid) lat = 99;
  endtask

  task automatic run_mix(input string tag, input int exp_s, input int exp_c);
    int   lat;
    logic signed [15:0] held;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check($sformatf("%s_busy", tag), int'(busy), 1);
    wait_valid(0, lat);
    check($sformatf("%s_latency", tag), lat, 27);
    check($sformatf("%s_sample", tag), int'(sample), exp_s);
    check($sformatf("%s_count", tag), int'(acount), exp_c);
    check($sformatf("%s_busy_at_valid", tag), int'(busy), 0);
    held = sample;
    step();
    check($sformatf("%s_valid_width", tag), int'(valid), 0);
    check($sformatf("%s_hold", tag), int'(sample), exp_s);
    if (held != sample) check($sformatf("%s_hold_stable", tag), int'(sample), int'(held));
  endtask

  task automatic set_uniform(input logic [23:0] g, input logic [7:0] ie, input logic [7:0] io);
    gate = g;
    for (int v = 0; v < NV; v++) phase[v] = {((v % 2) == 0) ? ie : io, 24'($urandom)};
  endtask

  initial begin
    int exp_s;
    int exp_c;
    int e;
    int lat;
    int seen;

    rst  = 1'b1;
    tick = 1'b0;
    set_uniform(24'h0, 8'd0, 8'd0);

    vecs[0]  = '{24'h000020, 8'd64,  8'd64,   4095,  1};
    vecs[1]  = '{24'hFFFFFF, 8'd64,  8'd64,   32767, 24};
    vecs[2]  = '{24'hFFFFFF, 8'd192, 8'd192, -32768, 24};
    vecs[3]  = '{24'h000003, 8'd64,  8'd192,  0,     2};
    vecs[4]  = '{24'h000000, 8'd64,  8'd64,   0,     0};
    vecs[5]  = '{24'h00000F, 8'd0,   8'd128,  0,     4};
    vecs[6]  = '{24'h000003, 8'd64,  8'd64,   8191,  2};
    vecs[7]  = '{24'h000001, 8'd192, 8'd192, -4096,  1};
    vecs[8]  = '{24'h000007, 8'd32,  8'd32,   8688,  3};
    vecs[9]  = '{24'h0000FF, 8'd192, 8'd192, -32767, 8};
    vecs[10] = '{24'h0001FF, 8'd192, 8'd192, -32768, 9};
    vecs[11] = '{24'hFFFFFF, 8'd1,   8'd1,    2412,  24};

    repeat (3) step();
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_count", int'(acount), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      set_uniform(vecs[i].gate, vecs[i].idx_even, vecs[i].idx_odd);
      run_mix($sformatf("vec%0d", i), vecs[i].exp_sample, vecs[i].exp_count);
    end

    for (int r = 0; r < 20; r++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        gate = 24'hFFFFFF;
        for (int v = 0; v < NV; v++) phase[v] = {8'($urandom_range(48, 80)), 24'($urandom)};
      end else if (mode == 1) begin
        gate = 24'($urandom);
        for (int v = 0; v < NV; v++) phase[v] = {8'($urandom_range(176, 208)), 24'($urandom)};
      end else begin
        gate = 24'($urandom);
        for (int v = 0; v < NV; v++) phase[v] = $urandom;
      end
      model(exp_s, exp_c);
      run_mix($sformatf("rnd%0d", r), exp_s, exp_c);
    end

    // Snapshot: inputs scrambled during the mix must not change the result
    set_uniform(24'h000020, 8'd64, 8'd64);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      gate = 24'($urandom);
      for (int v = 0; v < NV; v++) phase[v] = $urandom;
      step();
    end
    wait_valid(26, lat);
    check("snap_latency", lat, 27);
    check("snap_sample", int'(sample), 4095);
    check("snap_count", int'(acount), 1);

    // Overrun: tick at T+10 is ignored, later tick at T+40 runs normally
    step();
    set_uniform(24'h000020, 8'd64, 8'd64);
    check("ovr_before", int'(overrun), 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    e = 0;
    repeat (9) begin
      step();
      e++;
    end
    check("ovr_clear_t9", int'(overrun), 0);
    tick = 1'b1;
    step();
    e++;
    tick = 1'b0;
    step();
    e++;
    check("ovr_set_t11", int'(overrun), 1);
    wait_valid(e, lat);
    check("ovr_first_latency", lat, 27);
    check("ovr_first_sample", int'(sample), 4095);
    e = lat;
    phase[5] = 32'hC000_0000;
    while (e < 39) begin
      step();
      e++;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_valid(0, lat);
    check("ovr_second_latency", lat, 27);
    check("ovr_second_sample", int'(sample), -4096);
    check("ovr_sticky", int'(overrun), 1);

    // Reset mid-mix at T+12
    step();
    step();
    set_uniform(24'h000020, 8'd64, 8'd64);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_sample", int'(sample), 0);
    check("rst_mid_count", int'(acount), 0);
    check("rst_mid_overrun", int'(overrun), 0);
    seen = 0;
    repeat (40) begin
      if (valid) seen++;
      step();
    end
    check("rst_mid_no_valid", seen, 0);
    run_mix("after_rst", 4095, 1);
    check("after_rst_overrun", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
